// File: rtl/sram_1w1r_init_bypass_if.sv
// rtl/sram_1w1r_init_bypass_if.sv - write/read port bundle for sram_1w1r_init_bypass
interface sram_1w1r_init_bypass_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8,
   parameter int NUM_WMASKS = 4
);
   logic                   init_done;
   logic                   csb0;
   logic [NUM_WMASKS-1:0]  wmask0;
   logic [ADDR_WIDTH-1:0]  addr0;
   logic [DATA_WIDTH-1:0]  din0;
   logic                   csb1;
   logic [ADDR_WIDTH-1:0]  addr1;
   logic [DATA_WIDTH-1:0]  dout1;
   logic                   dout1_valid;
   logic                   wr_oob;
   logic                   rd_oob;

   modport master (
      output csb0, wmask0, addr0, din0, csb1, addr1,
      input  init_done, dout1, dout1_valid, wr_oob, rd_oob
   );

   modport slave (
      input  csb0, wmask0, addr0, din0, csb1, addr1,
      output init_done, dout1, dout1_valid, wr_oob, rd_oob
   );
endinterface

// File: rtl/sram_1w1r_init_bypass.sv
// rtl/sram_1w1r_init_bypass.sv - 1W1R SRAM with clear-on-reset, write masks, bypass and oob flags
module sram_1w1r_init_bypass #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ADDR_WIDTH = 8,
   parameter int                    RAM_DEPTH  = 1 << ADDR_WIDTH,
   parameter int                    NUM_WMASKS = 4,
   parameter int                    BYPASS     = 1,
   parameter int                    OUT_REG    = 0,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
   input  logic                    clk0,
   input  logic                    rst0,
   sram_1w1r_init_bypass_if.slave  bus
);
   localparam int WRITE_SIZE = DATA_WIDTH / NUM_WMASKS;
   // Index width covers exactly the implemented words; addresses are range-checked first.
   localparam int IDX_W = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);
   localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(RAM_DEPTH);

   typedef enum logic {S_INIT, S_READY} state_t;

   state_t                 state_q, state_d;
   logic [ADDR_WIDTH-1:0]  cnt_q, cnt_d;

   logic [DATA_WIDTH-1:0]  mem_q [RAM_DEPTH];

   logic                   ready;
   logic                   wr_in_range, rd_in_range;
   logic                   wr_en, rd_fire;
   logic [IDX_W-1:0]       wr_idx, rd_idx, init_idx;
   logic [DATA_WIDTH-1:0]  rd_old, rd_word;

   logic                   s1_vld_q, s1_vld_d;
   logic                   s1_oob_q, s1_oob_d;
   logic [DATA_WIDTH-1:0]  s1_data_q, s1_data_d;
   logic                   wr_oob_q, wr_oob_d;

   assign ready       = (state_q == S_READY);
   assign wr_in_range = ({1'b0, bus.addr0} < DEPTH_EXT);
   assign rd_in_range = ({1'b0, bus.addr1} < DEPTH_EXT);
   assign wr_en       = ready && !bus.csb0 && wr_in_range;
   assign rd_fire     = ready && !bus.csb1;
   assign wr_idx      = wr_in_range ? bus.addr0[IDX_W-1:0] : '0;
   assign rd_idx      = rd_in_range ? bus.addr1[IDX_W-1:0] : '0;
   assign init_idx    = cnt_q[IDX_W-1:0];

   // State and clear-counter register.
   always_ff @(posedge clk0) begin
      if (rst0) begin
         state_q <= S_INIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Clear sequencer: walk every word once, then serve requests.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_INIT: begin
            if (cnt_q == LAST_ADDR) begin
               state_d = S_READY;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + ADDR_WIDTH'(1);
            end
         end
         S_READY: begin
            state_d = S_READY;
         end
      endcase
   end

   // Storage: clear writes during INIT, masked user writes in READY, frozen under reset.
   always_ff @(posedge clk0) begin
      if (!rst0) begin
         if (state_q == S_INIT) begin
            mem_q[init_idx] <= INIT_VALUE;
         end else if (wr_en) begin
            for (int i = 0; i < NUM_WMASKS; i++) begin
               if (bus.wmask0[i]) begin
                  mem_q[wr_idx][i*WRITE_SIZE +: WRITE_SIZE] <= bus.din0[i*WRITE_SIZE +: WRITE_SIZE];
               end
            end
         end
      end
   end

   // Read word selection: optional same-address merge with the write in flight.
   always_comb begin
      rd_old  = mem_q[rd_idx];
      rd_word = rd_old;
      if ((BYPASS != 0) && wr_en && (bus.addr0 == bus.addr1)) begin
         for (int i = 0; i < NUM_WMASKS; i++) begin
            if (bus.wmask0[i]) begin
               rd_word[i*WRITE_SIZE +: WRITE_SIZE] = bus.din0[i*WRITE_SIZE +: WRITE_SIZE];
            end
         end
      end
      if (!rd_in_range) begin
         rd_word = '0;
      end
   end

   // First read stage next-state; data holds between reads so dout1 never toggles idly.
   always_comb begin
      s1_vld_d  = rd_fire;
      s1_oob_d  = rd_fire && !rd_in_range;
      s1_data_d = rd_fire ? rd_word : s1_data_q;
      wr_oob_d  = ready && !bus.csb0 && !wr_in_range;
   end

   // First read stage and write-drop flag registers.
   always_ff @(posedge clk0) begin
      if (rst0) begin
         s1_vld_q  <= 1'b0;
         s1_oob_q  <= 1'b0;
         s1_data_q <= '0;
         wr_oob_q  <= 1'b0;
      end else begin
         s1_vld_q  <= s1_vld_d;
         s1_oob_q  <= s1_oob_d;
         s1_data_q <= s1_data_d;
         wr_oob_q  <= wr_oob_d;
      end
   end

   generate
      if (OUT_REG != 0) begin : g_out_reg
         logic                   vld_q, oob_q;
         logic [DATA_WIDTH-1:0]  data_q, data_d;

         assign data_d = s1_vld_q ? s1_data_q : data_q;

         // Extra output stage adds one cycle of latency at full throughput.
         always_ff @(posedge clk0) begin
            if (rst0) begin
               vld_q  <= 1'b0;
               oob_q  <= 1'b0;
               data_q <= '0;
            end else begin
               vld_q  <= s1_vld_q;
               oob_q  <= s1_oob_q;
               data_q <= data_d;
            end
         end

         assign bus.dout1       = data_q;
         assign bus.dout1_valid = vld_q;
         assign bus.rd_oob      = oob_q;
      end else begin : g_no_out_reg
         assign bus.dout1       = s1_data_q;
         assign bus.dout1_valid = s1_vld_q;
         assign bus.rd_oob      = s1_oob_q;
      end
   endgenerate

   assign bus.wr_oob    = wr_oob_q;
   assign bus.init_done = ready;
endmodule

// File: doc/sram_1w1r_init_bypass.md
# sram_1w1r_init_bypass

Synthesizable, parametrised single-clock 1-write/1-read SRAM model. It replaces the fixed 16-bit, negedge-timed behavioural macros in the memory library. It adds per-segment write masks, a hardware clear-on-reset sequencer, selectable read-during-write bypass, an optional output register stage and out-of-range address flags. It sits between the macro library and any block that needs a configurable on-chip buffer, including in RTL simulation and FPGA prototyping.

## Interface
- DATA_WIDTH, 32, word width in bits
- ADDR_WIDTH, 8, address width
- RAM_DEPTH, 1<<ADDR_WIDTH, number of words; must be ≤ 2^ADDR_WIDTH and ≥ 2; may be non-power-of-2 (e.g. 120)
- NUM_WMASKS, 4, write-mask segments; DATA_WIDTH % NUM_WMASKS == 0; WRITE_SIZE = DATA_WIDTH/NUM_WMASKS
- BYPASS, 1, 1 = same-address read returns newly written data; 0 = old data
- OUT_REG, 0, 0 = read latency 1; 1 = read latency 2
- INIT_VALUE, 0, DATA_WIDTH-bit value written to every word during init

Ports:
- clk0  in  1  single clock, all logic on posedge
- rst0  in  1  synchronous, active-high reset
- init_done  out  1  high once clear sequence completes
- csb0  in  1  active-low write select
- wmask0  in  NUM_WMASKS  per-segment write enable, bit i covers din0[i*WRITE_SIZE +: WRITE_SIZE]
- addr0  in  ADDR_WIDTH  write address
- din0  in  DATA_WIDTH  write data
- csb1  in  1  active-low read select
- addr1  in  ADDR_WIDTH  read address
- dout1  out  DATA_WIDTH  read data
- dout1_valid  out  1  one-cycle pulse per completed read
- wr_oob  out  1  one-cycle pulse: write address ≥ RAM_DEPTH dropped
- rd_oob  out  1  one-cycle pulse: read address ≥ RAM_DEPTH

## Operation
- Two states, INIT and READY. Counter width is ADDR_WIDTH.
- rst0=1 (any state): enter INIT. Counter=0. init_done, dout1, dout1_valid, wr_oob, rd_oob and all pipeline registers reset to 0. Memory is not touched while rst0 is held.
- INIT: on each posedge with rst0=0, write INIT_VALUE to mem[counter] and increment. After writing RAM_DEPTH-1, go to READY and set init_done=1.
- INIT: csb0/csb1 are ignored. Requests are dropped silently, and no valid or oob pulse is raised.
- READY write: posedge with csb0=0 and addr0<RAM_DEPTH updates each segment i where wmask0[i]=1. Other segments are unchanged. wmask0=0 is a legal no-op.
- READY write with addr0≥RAM_DEPTH: no memory change. wr_oob=1 for the following cycle.
- READY read: posedge with csb1=0 samples addr1. Data appears on dout1 with dout1_valid=1 after the latency given in Timing.
- Read with addr1≥RAM_DEPTH: dout1=0 and dout1_valid=1 at the normal latency. rd_oob=1 in the same cycle as that valid.
- Without a read, dout1 holds its last value and dout1_valid=0. It never goes X.
- Same-cycle write and read to the same in-range address:
  - BYPASS=1: the read returns a merged word, with masked segments from din0 and unmasked segments from the prior contents.
  - BYPASS=0: the read returns the prior contents.
  - The write always completes.
- Reset mid-operation: in-flight reads are discarded, no valid pulse is emitted, and the memory is re-cleared.

## Timing
- Init length: init_done rises exactly RAM_DEPTH cycles after the first posedge with rst0=0. It stays high until the next rst0.
- Write: visible to a read issued on the next posedge. Same-cycle visibility is governed by BYPASS.
- Read latency:
  - OUT_REG=0: dout1/dout1_valid update at the posedge after the request and are observable for one cycle.
  - OUT_REG=1: one cycle later.
  - Back-to-back reads give back-to-back valid pulses, with full throughput of one read per cycle.
- wr_oob: asserts the cycle after the offending write.
- rd_oob: aligned with dout1_valid.
- A request issued on the last INIT cycle (init_done still 0) is dropped.

## Test plan
- Init: RAM_DEPTH=120, INIT_VALUE=32'hA5A5A5A5, rst0 high 3 cycles then low.
  - init_done rises at cycle 120 after deassert.
  - Reads of addr 0, 57, 119 return A5A5A5A5 with latency 1.
  - A write issued during INIT is not stored.
- Masked write: mem[5]=32'h11223344, then write din0=32'hAABBCCDD with wmask0=4'b0101.
  - A read of 5 returns 32'h11BB33DD.
- Bypass:
  - BYPASS=1: same-cycle write 32'hDEADBEEF (mask 4'hF) and read of addr 9 (old 0) returns DEADBEEF.
  - BYPASS=0 returns 0.
  - The next read returns DEADBEEF in both modes.
- Out of range (RAM_DEPTH=120):
  - A write to addr 125 gives a wr_oob pulse and no memory change.
  - A read of 125 gives dout1=0 with dout1_valid=1 and rd_oob=1 in the same cycle.
- Streaming with OUT_REG=1: reads of 0..7 on consecutive cycles give eight consecutive valid pulses starting 2 cycles after the first request, with correct data order.
- Mid-stream reset: assert rst0 while 2 reads are in flight.
  - No valid pulses follow.
  - init_done=0 and all outputs are 0.
  - After re-init, previously written addresses read INIT_VALUE.
